// File: rtl/multicycle_controller.sv
// Main control FSM for a multicycle MIPS datapath (shared memory, shared ALU).
// Decodes Op/Funct from the IR and drives every mux select, write enable and ALU op.
// Outputs decode from the current state; PCEn also folds in zero_flag in the same cycle.
module multicycle_controller #(
  parameter int OP_width      = 6,
  parameter int FUNCT_width   = 6,
  parameter int ALUCTRL_width = 3,
  parameter int STATE_width   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [OP_width-1:0]      Op,
  input  logic [FUNCT_width-1:0]   Funct,
  input  logic                     zero_flag,
  output logic                     IorD,
  output logic                     MemWrite,
  output logic                     IRWrite,
  output logic                     RegDst,
  output logic                     MemtoReg,
  output logic                     RegWrite,
  output logic                     ALUSrcA,
  output logic [1:0]               ALUSrcB,
  output logic [ALUCTRL_width-1:0] ALUControl,
  output logic [1:0]               PCSrc,
  output logic                     PCEn,
  output logic                     instr_done,
  output logic                     illegal,
  output logic [STATE_width-1:0]   state
);

  typedef enum logic [STATE_width-1:0] {
    S_FETCH   = STATE_width'(0),
    S_DECODE  = STATE_width'(1),
    S_MEMADR  = STATE_width'(2),
    S_MEMRD   = STATE_width'(3),
    S_MEMWB   = STATE_width'(4),
    S_MEMWR   = STATE_width'(5),
    S_EXECUTE = STATE_width'(6),
    S_ALUWB   = STATE_width'(7),
    S_BRANCH  = STATE_width'(8),
    S_ADDIEX  = STATE_width'(9),
    S_ADDIWB  = STATE_width'(10),
    S_JUMP    = STATE_width'(11)
  } state_t;

  localparam logic [OP_width-1:0] OP_LW   = OP_width'(6'b100011);
  localparam logic [OP_width-1:0] OP_SW   = OP_width'(6'b101011);
  localparam logic [OP_width-1:0] OP_RTYP = OP_width'(6'b000000);
  localparam logic [OP_width-1:0] OP_BEQ  = OP_width'(6'b000100);
  localparam logic [OP_width-1:0] OP_ADDI = OP_width'(6'b001000);
  localparam logic [OP_width-1:0] OP_J    = OP_width'(6'b000010);

  localparam logic [FUNCT_width-1:0] FN_ADD = FUNCT_width'(6'b100000);
  localparam logic [FUNCT_width-1:0] FN_SUB = FUNCT_width'(6'b100010);
  localparam logic [FUNCT_width-1:0] FN_AND = FUNCT_width'(6'b100100);
  localparam logic [FUNCT_width-1:0] FN_OR  = FUNCT_width'(6'b100101);
  localparam logic [FUNCT_width-1:0] FN_SLT = FUNCT_width'(6'b101010);

  localparam logic [ALUCTRL_width-1:0] ALU_ADD = ALUCTRL_width'(3'b010);
  localparam logic [ALUCTRL_width-1:0] ALU_SUB = ALUCTRL_width'(3'b110);
  localparam logic [ALUCTRL_width-1:0] ALU_AND = ALUCTRL_width'(3'b000);
  localparam logic [ALUCTRL_width-1:0] ALU_OR  = ALUCTRL_width'(3'b001);
  localparam logic [ALUCTRL_width-1:0] ALU_SLT = ALUCTRL_width'(3'b111);

  state_t state_q, state_d;
  logic   pc_write, branch;

  // Next-state selection; Op is only consulted in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        if (Op == OP_LW || Op == OP_SW) state_d = S_MEMADR;
        else if (Op == OP_RTYP)         state_d = S_EXECUTE;
        else if (Op == OP_BEQ)          state_d = S_BRANCH;
        else if (Op == OP_ADDI)         state_d = S_ADDIEX;
        else if (Op == OP_J)            state_d = S_JUMP;
        else                            state_d = S_FETCH;
      end
      S_MEMADR:  state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // State register; reset returns to FETCH at once, aborting any instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Moore output decode, forced to all-zero while reset is held.
  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    PCSrc      = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB  = 2'b01;
        IRWrite  = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        // Branch target is precomputed here into ALUOut.
        ALUSrcB = 2'b11;
        illegal = !(Op == OP_LW || Op == OP_SW || Op == OP_RTYP ||
                    Op == OP_BEQ || Op == OP_ADDI || Op == OP_J);
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        case (Funct)
          FN_ADD:  ALUControl = ALU_ADD;
          FN_SUB:  ALUControl = ALU_SUB;
          FN_AND:  ALUControl = ALU_AND;
          FN_OR:   ALUControl = ALU_OR;
          FN_SLT:  ALUControl = ALU_SLT;
          default: illegal    = 1'b1;
        endcase
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (rst) begin
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = '0;
      PCSrc      = 2'b00;
      pc_write   = 1'b0;
      branch     = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign PCEn  = pc_write | (branch & zero_flag);
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed plus randomized instruction streams for the multicycle controller,
// checked cycle by cycle against an instruction-level model of state sequence and controls.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op, Funct;
  logic       zero_flag;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       PCEn, instr_done, illegal;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  typedef int iq_t[$];

  multicycle_controller dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .zero_flag(zero_flag),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Observed control bundle, field order matches exp_out below.
  logic [16:0] obs;
  assign obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUControl, PCSrc, PCEn, instr_done, illegal};

  function automatic bit op_legal(logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // Which states an instruction walks through, FETCH to its final state.
  function automatic iq_t seq_of(logic [5:0] op);
    iq_t q;
    case (op)
      6'b100011: q = '{0, 1, 2, 3, 4};
      6'b101011: q = '{0, 1, 2, 5};
      6'b000000: q = '{0, 1, 6, 7};
      6'b000100: q = '{0, 1, 8};
      6'b001000: q = '{0, 1, 9, 10};
      6'b000010: q = '{0, 1, 11};
      default:   q = '{0, 1};
    endcase
    return q;
  endfunction

  // Expected controls for one cycle of an instruction, from the per-state action list.
  function automatic logic [16:0] exp_out(int st, logic [5:0] op, logic [5:0] fn, logic z);
    logic iord = 0, memw = 0, irw = 0, regdst = 0, mtr = 0, regw = 0, srca = 0;
    logic pcen = 0, done = 0, ill = 0;
    logic [1:0] srcb = 2'b00, pcsrc = 2'b00;
    logic [2:0] aluc = 3'b010;
    case (st)
      0:  begin irw = 1; srcb = 2'b01; pcen = 1; end
      1:  begin srcb = 2'b11; ill = !op_legal(op); end
      2, 9: begin srca = 1; srcb = 2'b10; end
      3:  iord = 1;
      4:  begin mtr = 1; regw = 1; done = 1; end
      5:  begin iord = 1; memw = 1; done = 1; end
      6:  begin
            srca = 1;
            case (fn)
              6'b100000: aluc = 3'b010;
              6'b100010: aluc = 3'b110;
              6'b100100: aluc = 3'b000;
              6'b100101: aluc = 3'b001;
              6'b101010: aluc = 3'b111;
              default:   ill  = 1;
            endcase
          end
      7:  begin regdst = 1; regw = 1; done = 1; end
      8:  begin srca = 1; aluc = 3'b110; pcsrc = 2'b01; pcen = z; done = 1; end
      10: begin regw = 1; done = 1; end
      11: begin pcsrc = 2'b10; pcen = 1; done = 1; end
      default: ;
    endcase
    return {iord, memw, irw, regdst, mtr, regw, srca, srcb, aluc, pcsrc, pcen, done, ill};
  endfunction

  task automatic check_vec(input string tag, input logic [16:0] o, input logic [16:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic check_st(input string tag, input logic [3:0] o, input int e);
    checks++;
    assert (o === 4'(e)) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Runs one instruction from FETCH; zmode 0/1 fixes zero_flag, 2 randomizes it per cycle.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int zmode);
    iq_t seq;
    seq = seq_of(op);
    Op = op;
    Funct = fn;
    for (int i = 0; i < seq.size(); i++) begin
      zero_flag = (zmode == 2) ? 1'($urandom_range(1)) : (zmode == 1);
      #1;
      check_st($sformatf("%s c%0d", name, i), state, seq[i]);
      check_vec($sformatf("%s c%0d ctl", name, i), obs, exp_out(seq[i], op, fn, zero_flag));
      @(negedge clk);
    end
  endtask

  initial begin
    logic [5:0] legal_fn[5];
    logic [5:0] legal_op[6];
    logic [5:0] op, fn;
    legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    legal_op = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

    rst = 1'b1; Op = '0; Funct = '0; zero_flag = 1'b1;
    #1;
    check_st("reset", state, 0);
    check_vec("reset ctl", obs, 17'b0);
    @(negedge clk);
    rst = 1'b0;

    run_instr("lw",      6'b100011, 6'b000000, 0);
    run_instr("sub",     6'b000000, 6'b100010, 0);
    run_instr("slt",     6'b000000, 6'b101010, 0);
    run_instr("beq_z1",  6'b000100, 6'b000000, 1);
    run_instr("beq_z0",  6'b000100, 6'b000000, 0);
    run_instr("sw",      6'b101011, 6'b000000, 0);
    run_instr("addi",    6'b001000, 6'b000000, 0);
    run_instr("j",       6'b000010, 6'b000000, 0);
    run_instr("ill_op",  6'b111111, 6'b000000, 1);
    run_instr("ill_fn",  6'b000000, 6'b000000, 1);

    // Asynchronous reset in the middle of MEMRD.
    Op = 6'b100011; Funct = '0; zero_flag = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_st($sformatf("lw_abort c%0d", k), state, k);
      if (k < 3) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    check_st("midreset", state, 0);
    check_vec("midreset ctl", obs, 17'b0);
    @(negedge clk);
    rst = 1'b0;
    run_instr("post_rst_lw", 6'b100011, 6'b000000, 2);

    // Randomized instruction stream, including illegal opcodes and functs.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(7) == 0) begin
        do op = 6'($urandom); while (op_legal(op));
      end else begin
        op = legal_op[$urandom_range(5)];
      end
      fn = ($urandom_range(3) == 0) ? 6'($urandom) : legal_fn[$urandom_range(4)];
      run_instr($sformatf("rnd%0d op%b fn%b", n, op, fn), op, fn, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style main control FSM that sequences a multicycle MIPS datapath.
- The datapath shares one memory for instructions and data, and one ALU for PC increment, branch target and execution.
- Each cycle, the block decodes Op/Funct from the instruction register and drives every mux select, write enable and ALU operation.
- It sits beside the datapath and replaces the single-cycle combinational control decoder.

Parameters:
OP_width, 6, width of the opcode field (Instr[31:26])
FUNCT_width, 6, width of the funct field (Instr[5:0])
ALUCTRL_width, 3, width of the ALUControl bus
STATE_width, 4, width of the state register and debug port

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
Op  input  OP_width  opcode from the instruction register
Funct  input  FUNCT_width  funct from the instruction register
zero_flag  input  1  ALU zero result
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  memory write enable
IRWrite  output  1  instruction register load enable
RegDst  output  1  write register select: 0=rt, 1=rd
MemtoReg  output  1  write-back select: 0=ALUOut, 1=Data
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A select: 0=PC, 1=register A
ALUSrcB  output  2  ALU B select: 00=register B, 01=const 4, 10=SignImm, 11=SignImm<<2
ALUControl  output  ALUCTRL_width  ALU operation
PCSrc  output  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
PCEn  output  1  PC register enable
instr_done  output  1  pulse in the final state of each instruction
illegal  output  1  pulse on an undefined Op, or on an undefined Funct in EXECUTE
state  output  STATE_width  current state, for debug

Behaviour:
- Reset:
  - rst high (async) forces state to FETCH=0.
  - While rst is high, all outputs are 0 except state=0.
  - The first FETCH actions occur in the first cycle after rst falls.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 go to FETCH on the next edge, with illegal=1.
- Transitions:
  - FETCH->DECODE.
  - DECODE by Op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other Op -> FETCH, with illegal=1 in DECODE
  - MEMADR->MEMRD if Op=lw, else MEMWR.
  - MEMRD->MEMWB.
  - EXECUTE->ALUWB.
  - ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
- Outputs per state (any output not listed is 0; ALUControl=010 where unlisted):
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target into ALUOut).
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010.
  - MEMRD: IorD=1.
  - MEMWR: IorD=1, MemWrite=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl decoded from Funct:
    - 100000 -> 010 (add)
    - 100010 -> 110 (sub)
    - 100100 -> 000 (and)
    - 100101 -> 001 (or)
    - 101010 -> 111 (slt)
    - any other Funct -> 010, with illegal=1; the sequence still completes.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
- PCEn = PCWrite | (Branch & zero_flag). It is combinational, same cycle.
- instr_done=1 in MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP.
- Cycles per instruction, FETCH through the done state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Op and Funct are sampled only in DECODE, MEMADR and EXECUTE; they are stable because IRWrite=0 outside FETCH.
- Reset mid-instruction aborts immediately with no further write enables. Resuming starts at FETCH.

Test Plan:
- Reset: rst pulsed asynchronously mid-cycle in MEMRD -> state=0 and all enables 0 immediately. After release: FETCH with IRWrite=1, PCEn=1, ALUSrcB=01.
- lw (Op=100011): state sequence 0,1,2,3,4.
  - Cycle 3: IorD=1.
  - Cycle 4: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1.
  - Then back to 0.
- R-type sub then slt (Op=0; Funct=100010, then 101010):
  - EXECUTE ALUControl is 110, then 111.
  - ALUWB has RegDst=1, RegWrite=1.
  - Total 8 cycles.
- beq with zero_flag=1 vs 0: in BRANCH, PCEn=1 vs 0, PCSrc=01 and ALUControl=110 in both cases; 3 cycles each.
- sw, addi and j:
  - sw: MemWrite=1 only in state 5.
  - addi: ADDIWB has RegDst=0, MemtoReg=0.
  - j: JUMP has PCSrc=10, PCEn=1.
- Illegal cases:
  - Op=111111: illegal=1 in DECODE, then FETCH with no RegWrite or MemWrite.
  - Funct=000000 with Op=0: illegal=1 in EXECUTE, ALUControl=010, ALUWB still occurs.
